instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
//============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch front end. It issues requests to a synchronous
//            instruction memory and queues each response in a 2-entry FIFO
//            that feeds the IF/ID buffer. Redirects flush the FIFO.
// Option   : IFETCH_HALT_EN enables the stop-on-halt-opcode (4'hF) feature.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [7:0]  if_addr,
    input  logic        id_ready,
    output logic        halted
);

    logic [7:0]  pc;
    logic [1:0]  count;
    logic        inflight;
    logic [7:0]  inflight_addr;
    logic [15:0] instr_q [2];
    logic [7:0]  addr_q  [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  count_after_pop;
    logic [1:0]  occupancy;

    always_comb begin
        pop             = (count != 2'd0) && id_ready;
        count_after_pop = count - {1'b0, pop};
        occupancy       = count_after_pop + {1'b0, inflight};
        // rst_n gates the request so imem_en reads low for as long as reset is held.
        issue           = rst_n && !br_taken && !halted && (occupancy < 2'd2);
`ifdef IFETCH_HALT_EN
        // A fetch issued alongside the halting push is dropped when it returns.
        push            = inflight && !br_taken && !halted;
`else
        push            = inflight && !br_taken;
`endif
    end

    assign imem_en   = issue;
    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign if_instr  = instr_q[0];
    assign if_addr   = addr_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            count         <= 2'd0;
            inflight      <= 1'b0;
            inflight_addr <= 8'h00;
            instr_q[0]    <= 16'h0000;
            instr_q[1]    <= 16'h0000;
            addr_q[0]     <= 8'h00;
            addr_q[1]     <= 8'h00;
        end else if (br_taken) begin
            pc       <= br_target;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (pop) begin
                instr_q[0] <= instr_q[1];
                addr_q[0]  <= addr_q[1];
            end
            // Written after the shift so a simultaneous push into slot 0 wins.
            if (push) begin
                instr_q[count_after_pop[0]] <= imem_rdata;
                addr_q[count_after_pop[0]]  <= inflight_addr;
            end
            count    <= count_after_pop + {1'b0, push};
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc;
                pc            <= pc + 8'd1;
            end
        end
    end

`ifdef IFETCH_HALT_EN
    logic halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (br_taken) begin
            halted_q <= 1'b0;
        end else if (push && (imem_rdata[15:12] == 4'hF)) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

`default_nettype wire
